// File: rtl/packed_accumulator.sv
// Lane-wise accumulator for packed SIMD adder results.
// Modes 1x32/2x16/4x8, optional signed saturation, sticky overflow.
module packed_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PA_START_i,
  input  logic [1:0]       PA_OP_i,
  input  logic             PA_SAT_i,
  input  logic             PA_VALID_i,
  input  logic [31:0]      PA_DATA_i,
  input  logic             PA_LAST_i,
  output logic             PA_READY_o,
  output logic             PA_OUT_VALID_o,
  input  logic             PA_OUT_READY_i,
  output logic [31:0]      PA_ACC_o,
  output logic [3:0]       PA_OVF_o,
  output logic [CNT_W-1:0] PA_COUNT_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10
  } state_t;

  localparam logic [1:0] MODE_16 = 2'b00;
  localparam logic [1:0] MODE_8  = 2'b01;
  localparam logic [1:0] MODE_32 = 2'b10;

  state_t           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [3:0]       ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             sat_q, sat_d;

  logic [31:0] s32, r32, r16, r8;
  logic        o32;
  logic [1:0]  o16;
  logic [3:0]  o8;
  logic [31:0] nacc;
  logic [3:0]  novf;

  assign s32 = acc_q + PA_DATA_i;
  assign o32 = (acc_q[31] == PA_DATA_i[31]) && (s32[31] != acc_q[31]);
  assign r32 = (sat_q && o32) ?
               (acc_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : s32;

  // Each lane adds in its own width so no carry crosses a boundary.
  for (genvar i = 0; i < 2; i++) begin : g_l16
    logic [15:0] a, d, s;
    assign a = acc_q[16*i +: 16];
    assign d = PA_DATA_i[16*i +: 16];
    assign s = a + d;
    assign o16[i] = (a[15] == d[15]) && (s[15] != a[15]);
    assign r16[16*i +: 16] = (sat_q && o16[i]) ?
                             (a[15] ? 16'h8000 : 16'h7FFF) : s;
  end

  for (genvar i = 0; i < 4; i++) begin : g_l8
    logic [7:0] a, d, s;
    assign a = acc_q[8*i +: 8];
    assign d = PA_DATA_i[8*i +: 8];
    assign s = a + d;
    assign o8[i] = (a[7] == d[7]) && (s[7] != a[7]);
    assign r8[8*i +: 8] = (sat_q && o8[i]) ?
                          (a[7] ? 8'h80 : 8'h7F) : s;
  end

  always_comb begin
    nacc = r32;
    novf = {3'b000, o32};
    unique case (1'b1)
      (mode_q == MODE_16): begin
        nacc = r16;
        novf = {2'b00, o16};
      end
      (mode_q == MODE_8): begin
        nacc = r8;
        novf = o8;
      end
      default: begin
        nacc = r32;
        novf = {3'b000, o32};
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    sat_d   = sat_q;
    unique case (state_q)
      IDLE: begin
        if (PA_START_i) begin
          state_d = ACCUM;
          acc_d   = '0;
          ovf_d   = '0;
          cnt_d   = '0;
          mode_d  = PA_OP_i[1] ? MODE_32 : PA_OP_i;
          sat_d   = PA_SAT_i;
        end
      end
      ACCUM: begin
        if (PA_VALID_i) begin
          acc_d = nacc;
          ovf_d = ovf_q | novf;
          if (cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + CNT_W'(1);
          if (PA_LAST_i)
            state_d = HOLD;
        end
      end
      HOLD: begin
        if (PA_OUT_READY_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_32;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      sat_q   <= sat_d;
    end
  end

  assign PA_READY_o     = (state_q == ACCUM);
  assign PA_OUT_VALID_o = (state_q == HOLD);
  assign PA_ACC_o       = acc_q;
  assign PA_OVF_o       = ovf_q;
  assign PA_COUNT_o     = cnt_q;

endmodule

// File: tb/tb_packed_accumulator.sv
// Directed bench for packed_accumulator with a result scoreboard.
module tb_packed_accumulator;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic             sat;
  logic             valid;
  logic [31:0]      data;
  logic             last;
  logic             ready;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      acc;
  logic [3:0]       ovf;
  logic [CNT_W-1:0] cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] acc;
    logic [3:0]  ovf;
    logic [3:0]  cnt;
  } exp_t;

  exp_t sb[$];

  packed_accumulator #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .PA_START_i    (start),
    .PA_OP_i       (op),
    .PA_SAT_i      (sat),
    .PA_VALID_i    (valid),
    .PA_DATA_i     (data),
    .PA_LAST_i     (last),
    .PA_READY_o    (ready),
    .PA_OUT_VALID_o(out_valid),
    .PA_OUT_READY_i(out_ready),
    .PA_ACC_o      (acc),
    .PA_OVF_o      (ovf),
    .PA_COUNT_o    (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] o, input logic s);
    start = 1'b1;
    op    = o;
    sat   = s;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    valid = 1'b1;
    data  = d;
    last  = l;
    tick();
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] o,
                      input logic [3:0] c);
    exp_t e;
    e.acc = a;
    e.ovf = o;
    e.cnt = c;
    sb.push_back(e);
  endtask

  task automatic wait_out(input string tag);
    exp_t e;
    int n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_outvalid"}, 32'(out_valid), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_acc"}, acc, e.acc);
      chk({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
      chk({tag, "_cnt"}, 32'(cnt), 32'(e.cnt));
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(ready), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    op = 2'b00;
    sat = 1'b0;
    valid = 1'b0;
    data = '0;
    last = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_acc", acc, 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_outvalid", 32'(out_valid), 32'h0);

    // asynchronous reset in the middle of an accumulation
    do_start(2'b10, 1'b0);
    chk("st_ready", 32'(ready), 32'd1);
    beat(32'h1234_5678, 1'b0);
    chk("mid_acc", acc, 32'h1234_5678);
    chk("mid_cnt", 32'(cnt), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_acc", acc, 32'h0);
    chk("arst_cnt", 32'(cnt), 32'h0);
    chk("arst_ready", 32'(ready), 32'h0);
    tick();
    rst = 1'b0;
    valid = 1'b1;
    data = 32'h0000_0005;
    repeat (3) tick();
    valid = 1'b0;
    chk("nostart_ready", 32'(ready), 32'h0);
    chk("nostart_acc", acc, 32'h0);
    chk("nostart_cnt", 32'(cnt), 32'h0);

    // 1x32 wrap without saturation
    do_start(2'b10, 1'b0);
    beat(32'h7FFF_FFFF, 1'b0);
    push(32'h8000_0000, 4'b0001, 4'd2);
    beat(32'h0000_0001, 1'b1);
    chk("w32_lat_valid", 32'(out_valid), 32'd1);
    chk("w32_lat_ready", 32'(ready), 32'd0);
    wait_out("w32");
    handshake("w32");

    // 4x8 saturation; op/sat changes after start must not matter
    do_start(2'b01, 1'b1);
    op = 2'b00;
    sat = 1'b0;
    beat(32'h6464_9C00, 1'b0);
    chk("s8_first_acc", acc, 32'h6464_9C00);
    chk("s8_first_ovf", 32'(ovf), 32'h0);
    push(32'h7F7F_8000, 4'b1110, 4'd2);
    beat(32'h6464_9C00, 1'b1);
    wait_out("s8");
    handshake("s8");

    // 2x16 lane isolation
    do_start(2'b00, 1'b0);
    beat(32'h0001_FFFF, 1'b0);
    push(32'h0002_0000, 4'b0000, 4'd2);
    beat(32'h0001_0001, 1'b1);
    wait_out("l16");

    // backpressure in HOLD with start/valid noise
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1;
      start = 1'b1;
      data = $urandom;
      tick();
      chk("bp_ready", 32'(ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_acc", acc, 32'h0002_0000);
    end
    valid = 1'b0;
    op = 2'b10;
    sat = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_hs_valid", 32'(out_valid), 32'd0);
    chk("bp_hs_ready", 32'(ready), 32'd0);
    chk("bp_hs_acc", acc, 32'h0002_0000);
    tick();
    start = 1'b0;
    chk("bp_restart_ready", 32'(ready), 32'd1);
    chk("bp_restart_acc", acc, 32'h0);

    // beat counter saturation (1x32 latched above)
    for (int i = 0; i < 20; i++) begin
      if (i == 19) push(32'h0000_0014, 4'b0000, 4'd15);
      beat(32'h0000_0001, (i == 19));
    end
    wait_out("cnt");
    handshake("cnt");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/packed_accumulator.md
# packed_accumulator

Registered lane-wise accumulator directly downstream of the packed SIMD adder. It consumes a stream of 32-bit packed results through a valid/ready handshake. Each result is read in the adder's lane modes: 1x32, 2x16 or 4x8. Lanes accumulate independently, with optional signed saturation and sticky per-lane overflow flags. A completed sum is presented on a valid/ready output port.

## Interface
- CNT_W, 8: width of the beat counter.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset; one clock, asynchronous, active-high.
- PA_START_i  in  1  begin accumulation; clears the accumulator and latches mode/saturation. Honoured only in IDLE.
- PA_OP_i  in  2  lane mode, latched at start: 00 = 2x16, 01 = 4x8, others = 1x32.
- PA_SAT_i  in  1  signed-saturation enable, latched at start.
- PA_VALID_i  in  1  input beat valid.
- PA_DATA_i  in  32  packed adder result.
- PA_LAST_i  in  1  beat is the final one of the sequence; qualified by the input handshake.
- PA_READY_o  out  1  beat accepted when PA_VALID_i & PA_READY_o.
- PA_OUT_VALID_o  out  1  final sum available.
- PA_OUT_READY_i  in  1  consumer takes the sum.
- PA_ACC_o  out  32  accumulator register, packed per mode.
- PA_OVF_o  out  4  sticky signed-overflow flag per lane; bit i = lane i.
- PA_COUNT_o  out  CNT_W  accepted beats since start.

## Operation
- States:
  - IDLE -> ACCUM on PA_START_i.
  - ACCUM -> HOLD on an accepted beat with PA_LAST_i.
  - HOLD -> IDLE when PA_OUT_VALID_o & PA_OUT_READY_i.
- PA_START_i in ACCUM or HOLD is ignored.
- On start: ACC, OVF and COUNT are cleared; mode and sat are latched. Later changes on PA_OP_i/PA_SAT_i have no effect until the next start.
- PA_READY_o = 1 only in ACCUM, driven from the state register with no combinational path from inputs.
- Accepted beat, per lane:
  - sum = ACC_lane + DATA_lane, lane width 8/16/32.
  - No carry ever crosses a lane boundary.
- Signed overflow (operands same sign, result sign differs):
  - Sets the lane's OVF bit; the bit stays set until the next start.
  - Sat = 1: the lane clamps to the signed max (0x7F/0x7FFF/0x7FFFFFFF) or signed min (0x80/0x8000/0x80000000) per operand sign.
  - Sat = 0: the lane wraps modulo 2^w.
- OVF bits for lanes that do not exist in the latched mode stay 0:
  - 1x32 uses bit 0.
  - 2x16 uses bits 1:0.
  - 4x8 uses bits 3:0.
- COUNT increments per accepted beat and saturates at 2^CNT_W-1; it does not wrap.
- PA_ACC_o, PA_OVF_o and PA_COUNT_o hold their values through HOLD and IDLE until the next start clears them.
- PA_VALID_i outside ACCUM is ignored; no state changes.

## Timing
- Reset values: state IDLE, PA_ACC_o = 0, PA_OVF_o = 0, PA_COUNT_o = 0, PA_READY_o = 0, PA_OUT_VALID_o = 0, latched mode = 1x32, sat = 0.
- Reset asserted mid-operation: immediate return to reset values. The partial sum is discarded and no output is produced.
- Start sampled at cycle N: PA_READY_o = 1 from cycle N+1.
- Beat accepted at cycle N: PA_ACC_o/PA_OVF_o/PA_COUNT_o are updated at N+1. Back-to-back beats sustain one beat per cycle.
- LAST beat accepted at N:
  - PA_READY_o = 0 and PA_OUT_VALID_o = 1 from N+1, with the final sum on PA_ACC_o.
  - Output latency is one cycle.
- PA_OUT_VALID_o stays high and PA_ACC_o stays stable until PA_OUT_READY_i is sampled high.
- Handshake at cycle M: PA_OUT_VALID_o = 0 at M+1 (IDLE).
  - A PA_START_i at M is ignored because the state is still HOLD.
  - A start at M+1 is honoured.
- Start and a valid beat in the same cycle in IDLE: the start is taken and the beat is not accepted (PA_READY_o = 0).
- PA_OUT_READY_i outside HOLD has no effect.

## Test plan
- Reset: assert rst asynchronously between edges during ACCUM with ACC = 0x12345678 -> all outputs 0 immediately and state IDLE. Beats applied after release are ignored until a start.
- 1x32 wrap: start OP=10, SAT=0; beats 0x7FFFFFFF, then 0x00000001 with LAST -> PA_ACC_o = 0x80000000, PA_OVF_o = 0001, PA_COUNT_o = 2, PA_OUT_VALID_o high one cycle after LAST.
- 4x8 saturation: start OP=01, SAT=1; beats 0x64649C00, then 0x64649C00 with LAST -> PA_ACC_o = 0x7F7F8000, PA_OVF_o = 1110.
- 2x16 lane isolation: start OP=00, SAT=0; beats 0x0001FFFF, then 0x00010001 with LAST -> PA_ACC_o = 0x00020000 (no carry into the upper lane), PA_OVF_o = 0000.
- Backpressure: hold PA_OUT_READY_i low 5 cycles in HOLD while driving PA_VALID_i = 1, PA_START_i = 1 and changing PA_DATA_i -> PA_READY_o = 0, PA_ACC_o unchanged, state HOLD. Assert ready -> IDLE next cycle.
- Counter saturation: CNT_W = 4, 20 beats of 0x00000001 -> PA_COUNT_o = 15, PA_ACC_o = 0x00000014.
